// File: rtl/axilite_pkg.sv
// Shared AXI-Lite definitions: response codes and the write-master FSM state encoding.
// Every axilite block imports this so response decoding stays consistent.
package axilite_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
   localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } axi_wr_state_e;

endpackage

// File: rtl/axilite_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// 'clear' is synchronous and has priority over 'inc'.
module axilite_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/axilite_write_master.sv
// Single-outstanding AXI-Lite write master: takes one command, issues AW and W in
// parallel, waits for B, then reports the response and keeps write/error counts.
module axilite_write_master
   import axilite_pkg::*;
#(
   parameter int         ADDR_SIZE   = 32,
   parameter int         DATA_WIDTH  = 32,
   parameter logic [1:0] RESP_OKAY   = AXI_RESP_OKAY,
   parameter logic [1:0] RESP_EXOKAY = AXI_RESP_EXOKAY,
   parameter logic [1:0] RESP_SLVERR = AXI_RESP_SLVERR,
   parameter logic [1:0] RESP_DECERR = AXI_RESP_DECERR,
   parameter int         CNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_SIZE-1:0]    cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_data,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   output logic [ADDR_SIZE-1:0]    awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [1:0]              res_resp,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CNT_WIDTH-1:0]    wr_count,
   output logic [CNT_WIDTH-1:0]    err_count
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   axi_wr_state_e state, state_next;

   logic [ADDR_SIZE-1:0]  addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic                  aw_done, w_done;
   logic [1:0]            resp_q;
   logic                  aw_hs, w_hs, b_hs, b_is_err;

   // Handshakes derived from state and done flags, not from the valid outputs,
   // so the next-state logic below has no combinational loop through awvalid/wvalid.
   assign aw_hs = (state == ST_XFER) && !aw_done && awready;
   assign w_hs  = (state == ST_XFER) && !w_done && wready;
   assign b_hs  = (state == ST_RESP) && bvalid;

   // EXOKAY counts as success; the two remaining codes are the error cases.
   assign b_is_err = (bresp != RESP_OKAY) && (bresp != RESP_EXOKAY) &&
                     ((bresp == RESP_SLVERR) || (bresp == RESP_DECERR));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      res_valid  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_next = ST_XFER;
         end
         ST_XFER: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = ST_RESP;
         end
         ST_RESP: begin
            bready = 1'b1;
            if (bvalid) state_next = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Payload is captured only on command acceptance, so it stays put for the
   // whole transaction regardless of what the issuer does meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else if ((state == ST_IDLE) && cmd_valid) begin
         addr_q <= cmd_addr;
         data_q <= cmd_data;
         strb_q <= cmd_strb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (state == ST_IDLE)) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q <= RESP_OKAY;
      end else if (b_hs) begin
         resp_q <= bresp;
      end
   end

   assign awaddr   = addr_q;
   assign wdata    = data_q;
   assign wstrb    = strb_q;
   assign res_resp = resp_q;

   axilite_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_counter (
      .clk   (clk),
      .clear (rst),
      .inc   (b_hs),
      .count (wr_count)
   );

   axilite_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_counter (
      .clk   (clk),
      .clear (rst),
      .inc   (b_hs && b_is_err),
      .count (err_count)
   );

endmodule
